// File: rtl/note_spawner.sv
// note_spawner: beat-driven rhythm note generator with a FWFT note queue.
//
// Ports:
//   clk, reset_n              clock; asynchronous active-low reset
//   start, stop, beat         one-cycle control pulses
//   difficulty[1:0]           note density select (threshold 4/8/12/16)
//   rnd[9:0]                  current LFSR word
//   rnd_en                    LFSR advance strobe (beat while running)
//   note_lanes[LANES-1:0]     head-of-queue lane pattern (0 when empty)
//   note_valid / note_ready   queue output handshake
//   busy                      FSM not in IDLE
//   overflow                  sticky: a hit was dropped on a full queue
//   note_count[9:0]           notes pushed since start, saturating
//
// Optional feature: define NOTE_SPAWNER_DOUBLE_EN to allow double notes at
// difficulty 3 when rnd[5] is set (second lane chosen by rnd[3:2]).
module note_spawner #(
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_MIN    = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             beat,
    input  logic [1:0]       difficulty,
    input  logic [9:0]       rnd,
    output logic             rnd_en,
    output logic [LANES-1:0] note_lanes,
    output logic             note_valid,
    input  logic             note_ready,
    output logic             busy,
    output logic             overflow,
    output logic [9:0]       note_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = GAP_MIN > 0 ? $clog2(GAP_MIN + 1) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [LANES-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic [RW-1:0]    rest_q, rest_d;
    logic             ovf_q, ovf_d;
    logic [9:0]       count_q, count_d;
    logic [4:0]       thr;
    logic [LANES-1:0] pattern;
    logic             run_beat, start_run, hit, push, pop, full;

    assign start_run = state_q == IDLE && start;
    assign run_beat  = state_q == RUN && beat;
    assign thr       = {1'b0, difficulty, 2'b00} + 5'd4;
    assign hit       = run_beat && rest_q == '0 && {1'b0, rnd[9:6]} < thr;
    assign full      = cnt_q == (AW+1)'(FIFO_DEPTH);
    assign pop       = note_valid && note_ready;
    // A full queue still takes a hit when the head leaves in the same cycle.
    assign push      = hit && (!full || pop);

`ifdef NOTE_SPAWNER_DOUBLE_EN
    assign pattern = (LANES'(1) << rnd[1:0]) |
                     ((difficulty == 2'd3 && rnd[5]) ? LANES'(1) << rnd[3:2] : '0);
`else
    assign pattern = LANES'(1) << rnd[1:0];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // DRAIN exits on the edge that removes the last entry, so busy drops
    // the cycle right after the final pop.
    always_comb begin
        state_d = state_q == IDLE ? (start ? RUN : IDLE) :
                  state_q == RUN  ? (stop ? DRAIN : RUN) :
                                    (cnt_d == '0 ? IDLE : DRAIN);
    end

    always_comb begin
        busy       = state_q != IDLE;
        rnd_en     = run_beat;
        note_valid = cnt_q != '0;
        note_lanes = note_valid ? mem_q[rd_q] : '0;
        overflow   = ovf_q;
        note_count = count_q;
    end

    always_comb begin
        cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        rest_d  = start_run ? '0 :
                  hit ? RW'(GAP_MIN) :
                  (run_beat && rest_q != '0) ? rest_q - RW'(1) : rest_q;
        ovf_d   = start_run ? 1'b0 : ovf_q | (hit && !push);
        count_d = start_run ? '0 :
                  (push && count_q != 10'h3FF) ? count_q + 10'd1 : count_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            rest_q  <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_q + AW'(push);
            rd_q    <= rd_q + AW'(pop);
            cnt_q   <= cnt_d;
            rest_q  <= rest_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= pattern;
    end
endmodule

// File: tb/tb_note_spawner.sv
// tb_note_spawner: scoreboard bench for note_spawner.
module tb_note_spawner;
    logic       clk, reset_n, start, stop, beat, note_ready;
    logic [1:0] difficulty;
    logic [9:0] rnd;
    logic       rnd_en, note_valid, busy, overflow;
    logic [3:0] note_lanes;
    logic [9:0] note_count;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];
    logic [3:0] dbl_exp;

    note_spawner #(.LANES(4), .FIFO_DEPTH(8), .GAP_MIN(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .beat(beat),
        .difficulty(difficulty), .rnd(rnd), .rnd_en(rnd_en),
        .note_lanes(note_lanes), .note_valid(note_valid), .note_ready(note_ready),
        .busy(busy), .overflow(overflow), .note_count(note_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && note_valid && note_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got lanes %b expected no entry", note_lanes);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (note_lanes !== e) begin
                    errors++;
                    $display("FAIL pop_lanes: got %b expected %b", note_lanes, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_beat(input logic [1:0] d, input logic [9:0] r,
                           input logic push, input logic [3:0] lanes);
        difficulty = d;
        rnd = r;
        beat = 1;
        #1 chk("rnd_en_beat", rnd_en, 1);
        if (push) exp_q.push_back(lanes);
        @(posedge clk);
        #1 beat = 0;
    endtask

    task automatic pulse_start;
        start = 1;
        tick(1);
        start = 0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_valid"}, note_valid, 0);
        chk({tag, "_lanes"}, note_lanes, 0);
        chk({tag, "_rnd_en"}, rnd_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_count"}, note_count, 0);
    endtask

    initial begin
        reset_n = 0; start = 0; stop = 0; beat = 0; note_ready = 0;
        difficulty = 0; rnd = 0;
`ifdef NOTE_SPAWNER_DOUBLE_EN
        dbl_exp = 4'b1010;
`else
        dbl_exp = 4'b0010;
`endif
        #12 reset_checks("reset");
        @(posedge clk);
        #1 reset_n = 1;
        note_ready = 1;
        tick(1);

        pulse_start();
        chk("rnd_en_idle_beat", rnd_en, 0);
        do_beat(2'd3, 10'h002, 1, 4'b0100);
        chk("single_valid", note_valid, 1);
        chk("single_lanes", note_lanes, 4'b0100);
        chk("single_count", note_count, 1);

        do_beat(2'd3, 10'h003, 0, 4'b0000);
        chk("rest_no_note", note_valid, 0);
        chk("rest_count", note_count, 1);
        do_beat(2'd3, 10'h001, 1, 4'b0010);
        chk("rest_then_hit_count", note_count, 2);

        do_beat(2'd0, 10'h140, 0, 4'b0000);
        do_beat(2'd0, 10'h140, 0, 4'b0000);
        chk("density_rest_valid", note_valid, 0);
        chk("density_rest_count", note_count, 2);
        do_beat(2'd1, 10'h140, 1, 4'b0001);
        chk("density_d1_count", note_count, 3);

        do_beat(2'd0, 10'h3FF, 0, 4'b0000);
        do_beat(2'd3, 10'b0000101101, 1, dbl_exp);
        chk("double_count", note_count, 4);
        tick(2);

        note_ready = 0;
        for (int i = 0; i < 18; i++) begin
            if (i == 17) chk("no_overflow_at_8", overflow, 0);
            do_beat(2'd3, 10'(i), (i % 2 == 1) && i <= 15, 4'b0001 << (i % 4));
        end
        chk("overflow_set", overflow, 1);
        chk("overflow_count", note_count, 12);
        chk("overflow_valid", note_valid, 1);
        do_beat(2'd3, 10'd18, 0, 4'b0000);
        note_ready = 1;
        do_beat(2'd3, 10'd19, 1, 4'b1000);
        chk("full_pushpop_count", note_count, 13);
        chk("full_pushpop_overflow", overflow, 1);
        tick(10);
        chk("overflow_drained", note_valid, 0);
        chk("overflow_sb_empty", exp_q.size(), 0);

        note_ready = 0;
        do_beat(2'd3, 10'h000, 0, 4'b0000);
        do_beat(2'd3, 10'h000, 1, 4'b0001);
        do_beat(2'd3, 10'h000, 0, 4'b0000);
        do_beat(2'd3, 10'h001, 1, 4'b0010);
        do_beat(2'd3, 10'h000, 0, 4'b0000);
        do_beat(2'd3, 10'h002, 1, 4'b0100);
        chk("drain_pre_count", note_count, 16);
        stop = 1;
        tick(1);
        stop = 0;
        chk("drain_busy", busy, 1);
        beat = 1;
        rnd = 10'h000;
        #1 chk("drain_rnd_en", rnd_en, 0);
        tick(1);
        beat = 0;
        chk("drain_beat_ignored", note_count, 16);
        for (int p = 0; p < 3; p++) begin
            note_ready = 1;
            tick(1);
            note_ready = 0;
            chk("drain_busy_after_pop", busy, p < 2);
            tick(1);
        end
        chk("drain_idle_valid", note_valid, 0);
        chk("drain_sb_empty", exp_q.size(), 0);

        pulse_start();
        chk("restart_overflow_clear", overflow, 0);
        chk("restart_count_clear", note_count, 0);
        do_beat(2'd3, 10'h000, 1, 4'b0001);
        do_beat(2'd3, 10'h000, 0, 4'b0000);
        do_beat(2'd3, 10'h002, 1, 4'b0100);
        do_beat(2'd3, 10'h000, 0, 4'b0000);
        stop = 1;
        do_beat(2'd3, 10'h003, 1, 4'b1000);
        stop = 0;
        chk("stop_beat_count", note_count, 3);
        chk("stop_beat_busy", busy, 1);
        note_ready = 1;
        tick(1);
        note_ready = 0;
        chk("middrain_busy", busy, 1);
        chk("middrain_valid", note_valid, 1);
        chk("middrain_lanes", note_lanes, 4'b0100);
        reset_n = 0;
        #1 reset_checks("async_reset");
        exp_q.delete();
        tick(2);
        reset_n = 1;
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/note_spawner.md
# note_spawner

Rhythm-game note generator sitting directly downstream of the 10-bit pseudo-random LFSR. On every beat tick it advances the LFSR by one step and turns the current random word into a hit-or-rest decision and a lane pattern. Accepted notes are queued in a small first-word-fall-through FIFO. The scrolling-arrow display stage consumes that FIFO through a valid/ready handshake.

## Interface
- LANES, 4: number of arrow lanes; fixed at 4 by the lane-select arithmetic.
- FIFO_DEPTH, 8: note queue entries; must be a power of two ≥ 2.
- GAP_MIN, 1: beats forced to rest after each emitted note; 0 disables the rest rule.

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a song from IDLE
- stop  in  1  one-cycle pulse; ends generation and drains the queue
- beat  in  1  one-cycle beat tick
- difficulty  in  2  note density select
- rnd  in  10  current LFSR output word
- rnd_en  out  1  advance strobe to the LFSR
- note_lanes  out  LANES  head-of-queue lane pattern, one bit per lane
- note_valid  out  1  queue non-empty
- note_ready  in  1  consumer accepts the head entry
- busy  out  1  FSM not in IDLE
- overflow  out  1  sticky; a note was dropped because the queue was full
- note_count  out  10  notes pushed since start; saturates at 1023

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN on start. Entering RUN clears note_count, overflow and the rest counter. The queue is not flushed.
  - RUN → DRAIN on stop. Start pulses are ignored while in RUN.
  - DRAIN → IDLE when the queue is empty.
- rnd_en = beat while in RUN, on every beat, including rest beats, so the random sequence is deterministic. rnd_en is 0 in IDLE and DRAIN.
- Hit decision, evaluated on the beat cycle from the current rnd value:
  - Threshold T by difficulty: 0 → 4, 1 → 8, 2 → 12, 3 → 16.
  - hit = (rest_cnt == 0) && (rnd[9:6] < T). Difficulty 3 therefore always hits.
- Lane pattern: one-hot bit rnd[1:0]. With the double-note feature, an extra bit is ORed in (see Configuration).
- On a hit:
  - Push the pattern into the queue.
  - rest_cnt ← GAP_MIN.
  - note_count increments, saturating at 1023.
- On a non-hit beat with rest_cnt > 0: rest_cnt decrements.
- Queue full on a hit: the note is dropped, overflow ← 1, note_count is unchanged.
- Push and pop in the same cycle on a full queue: both are accepted, the entry count stays the same, and overflow is not set.
- Pop occurs when note_valid && note_ready. The queue drains in every state.
- stop and beat in the same cycle: the beat is still processed, then the FSM enters DRAIN.

## Timing
- Reset values: note_valid 0, note_lanes 0, rnd_en 0, busy 0, overflow 0, note_count 0. State is IDLE, the queue is empty, rest_cnt is 0.
- reset_n low mid-operation clears all state immediately and asynchronously. Queued notes are lost.
- rnd_en is combinational and asserts in the beat cycle. The LFSR advances at that clock edge, so the next beat sees a fresh word.
- Latency from beat to note_valid is 1 cycle when the queue is empty; note_lanes is valid in the same cycle.
- Latency from pop to the next head entry appearing is 0 cycles (first-word-fall-through, registered storage).
- busy rises 1 cycle after start and falls 1 cycle after the last pop in DRAIN.
- Back-to-back beats on consecutive cycles are each fully processed.

## Configuration
- NOTE_SPAWNER_DOUBLE_EN defined:
  - Applies when difficulty == 3 and rnd[5] == 1.
  - The pattern additionally sets the bit selected by rnd[3:2].
  - If rnd[3:2] == rnd[1:0], the result remains a single note.
- NOTE_SPAWNER_DOUBLE_EN undefined: every pattern is exactly one-hot, and rnd[5:2] is ignored.

## Test plan
- Single hit, rest: start, difficulty=3, rnd=10'h002, pulse beat → rnd_en=1 in the beat cycle; next cycle note_valid=1, note_lanes=4'b0100, note_count=1.
- Density rest: difficulty=0, rnd=10'h140 (rnd[9:6]=5), beat → rnd_en=1, no push, note_valid stays 0.
- Rest rule: GAP_MIN=1, difficulty=3, two beats → one note only. A third beat emits again, giving note_count=2.
- Overflow: note_ready=0, GAP_MIN=0, difficulty=3, 9 beats → 8 entries, overflow=1, note_count=8. Then note_ready=1 with a beat in the same cycle → push accepted and overflow unchanged.
- Double note (macro defined): difficulty=3, rnd=10'b0000101101, beat → note_lanes=4'b1010. With the macro undefined → 4'b0010.
- Stop/drain/reset: 3 queued notes, stop → busy=1 until the third pop, then IDLE. Repeat with reset_n low mid-drain → all outputs return to reset values immediately.
